// File: rtl/a_read_issuer.sv
// A-operand read issuer: pops byte addresses from the address FIFO, issues one bus-word read
// per address, and forwards in-order responses into the A data FIFO under a free-slot credit.
module a_read_issuer #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned FREE_WIDTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [15:0]           total_reads,
    input  logic [ADDR_WIDTH-1:0] addr_fifo_addr,
    input  logic                  addr_fifo_empty,
    output logic                  addr_fifo_pop,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  data_fifo_push,
    output logic [DATA_WIDTH-1:0] data_fifo_wdata,
    input  logic [FREE_WIDTH-1:0] data_fifo_free,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rsp_err_o
);

    localparam int unsigned CreditWidth = FREE_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    state_e                  state_q, state_d;
    logic [15:0]             total_q, total_d;
    logic [15:0]             issued_q, issued_d;
    logic [15:0]             outst_q, outst_d;
    logic                    req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    push_q, push_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    reg_free;
    logic                    pop;
    logic                    rsp_ok;
    logic                    rsp_stray;
    logic [CreditWidth-1:0]  credit_used;

    assign reg_free    = !req_valid_q || mem_req_ready;
    // push_q still occupies a slot that data_fifo_free does not yet show.
    assign credit_used = CreditWidth'(outst_q) + CreditWidth'(push_q);

    assign pop = (state_q == StRun) && reg_free && !addr_fifo_empty &&
                 (issued_q < total_q) && (outst_q < 16'(MAX_OUTSTANDING)) &&
                 (credit_used < {1'b0, data_fifo_free});

    assign rsp_ok    = mem_rsp_valid && (outst_q != 16'd0);
    assign rsp_stray = mem_rsp_valid && (outst_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        issued_d    = issued_q + 16'(pop);
        outst_d     = outst_q + 16'(pop) - 16'(rsp_ok);
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        push_d      = rsp_ok;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q | rsp_stray;

        if (rsp_ok) begin
            wdata_d = mem_rsp_data;
        end

        if (pop) begin
            req_valid_d = 1'b1;
            req_addr_d  = addr_fifo_addr;
        end else if (req_valid_q && mem_req_ready) begin
            req_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    total_d  = total_reads;
                    issued_d = 16'd0;
                    outst_d  = 16'd0;
                    err_d    = rsp_stray;
                    busy_d   = 1'b1;
                    state_d  = (total_reads == 16'd0) ? StFinish : StRun;
                end
            end
            StRun: begin
                if ((issued_q == total_q) && reg_free) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((outst_q == 16'd0) && !push_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            total_q     <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            push_q      <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            push_q      <= push_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign addr_fifo_pop   = pop;
    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = req_addr_q;
    assign data_fifo_push  = push_q;
    assign data_fifo_wdata = wdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign rsp_err_o       = err_q;

endmodule
